// File: rtl/dma_reg_master.sv
// -----------------------------------------------------------------------------
// dma_reg_master
//
// Bus initiator for the DMA register interface. Takes one register command at
// a time from the host/config sequencer, checks it against the DMA register
// window, performs exactly one single-cycle access on the register bus and
// hands back a response (write echo, error flag, read data).
//
// Handshakes (command and response ports): a transfer happens on a rising clk
// edge where both valid and ready are high. A producer holds its valid and
// payload stable until that edge. cmd_ready depends only on FSM state, and
// rsp_valid is never withdrawn before rsp_ready is seen.
//
// Ports
//   clk        in   1           clock, all logic on posedge
//   reset      in   1           asynchronous active-low reset
//   cmd_valid  in   1           command request
//   cmd_ready  out  1           master can accept a command (IDLE only)
//   cmd_wr     in   1           1 = write, 0 = read
//   cmd_addr   in   ADDR_WIDTH  target register address
//   cmd_wdata  in   DATA_WIDTH  write data
//   rsp_valid  out  1           response available
//   rsp_ready  in   1           response consumed
//   rsp_wr     out  1           echo of cmd_wr
//   rsp_err    out  1           address outside window or misaligned
//   rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
//   addr       out  ADDR_WIDTH  bus address to slave
//   wr_en      out  1           bus write enable
//   valid      out  1           bus strobe, one cycle per access
//   wdata      out  DATA_WIDTH  bus write data
//   rdata      in   DATA_WIDTH  bus read data from slave
//   busy       out  1           FSM not in IDLE
//   txn_count  out  CNT_WIDTH   completed responses, wraps
//   dbg_state  out  2           current FSM state (IDLE=0 ISSUE=1 CAPT=2 RESP=3)
// -----------------------------------------------------------------------------
module dma_reg_master #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = ADDR_WIDTH'('h400),
    parameter int unsigned             NUM_REGS   = 4,
    parameter int unsigned             CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_wr,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Exclusive upper bound of the register window.
    localparam logic [ADDR_WIDTH-1:0] WIN_HI = BASE_ADDR + ADDR_WIDTH'(4 * NUM_REGS);

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_wr_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_en_q;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    txn_count_q;

    logic                    addr_ok;
    logic                    cmd_fire;

    assign addr_ok  = (cmd_addr[1:0] == 2'b00) &&
                      (cmd_addr >= BASE_ADDR) &&
                      (cmd_addr < WIN_HI);
    assign cmd_fire = cmd_valid && cmd_ready_q;

    // Single FSM block; every output is a register so nothing combinational
    // leaks from the command port straight onto the bus or response port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            txn_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_wr_q    <= cmd_wr;
                        // Response data starts at zero; only a read's CAPT
                        // cycle ever overwrites it.
                        rsp_rdata_q <= '0;
                        if (addr_ok) begin
                            rsp_err_q <= 1'b0;
                            addr_q    <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wr_en_q   <= cmd_wr;
                            valid_q   <= 1'b1;
                            state_q   <= ISSUE;
                        end else begin
                            // Rejected command: skip the bus entirely and
                            // leave addr/wdata at their last driven values.
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end

                ISSUE: begin
                    valid_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    if (rsp_wr_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        state_q <= CAPT;
                    end
                end

                CAPT: begin
                    // The slave registered rdata at the edge that ended ISSUE,
                    // so it is stable for the whole of this cycle.
                    rsp_rdata_q <= rdata;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        txn_count_q <= txn_count_q + CNT_WIDTH'(1);
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    valid_q     <= 1'b0;
                    wr_en_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr      = addr_q;
    assign wr_en     = wr_en_q;
    assign valid     = valid_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign txn_count = txn_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dma_reg_master.sv
// -----------------------------------------------------------------------------
// tb_dma_reg_master
//
// Self-checking bench for dma_reg_master. A small register slave answers the
// bus, a shadow register model predicts read data, and a scoreboard queue of
// {rsp_wr, rsp_err, rsp_rdata} is compared on every response handshake.
// The counter is instantiated 8 bits wide so its wrap is reachable quickly.
// -----------------------------------------------------------------------------
module tb_dma_reg_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_wr    = 1'b0;
    logic [AW-1:0]     cmd_addr  = '0;
    logic [DW-1:0]     cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_wr;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     addr;
    logic              wr_en;
    logic              valid;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata = '0;
    logic              busy;
    logic [CNT_W-1:0]  txn_count;
    logic [1:0]        dbg_state;

    dma_reg_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (32'h400),
        .NUM_REGS   (4),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_wr    (rsp_wr),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .addr      (addr),
        .wr_en     (wr_en),
        .valid     (valid),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .txn_count (txn_count),
        .dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int pulse_cnt = 0;
    int rsp_seen  = 0;

    logic [33:0] exp_q[$];
    logic [33:0] sb_exp;
    logic [31:0] model_regs [4];
    logic [31:0] slave_regs [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: write on strobe, read data registered at the strobe edge.
    always @(posedge clk) begin
        if (valid) begin
            if (wr_en) slave_regs[addr[3:2]] <= wdata;
            else       rdata <= slave_regs[addr[3:2]];
        end
    end

    always @(posedge clk) begin
        if (valid) pulse_cnt <= pulse_cnt + 1;
    end

    // Scoreboard: a response is consumed at the next edge when both are high.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got wr=%b err=%b rdata=%h, required no response",
                         rsp_wr, rsp_err, rsp_rdata);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({rsp_wr, rsp_err, rsp_rdata} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_response: got wr=%b err=%b rdata=%h, required wr=%b err=%b rdata=%h",
                             rsp_wr, rsp_err, rsp_rdata, sb_exp[33], sb_exp[32], sb_exp[31:0]);
                end
            end
            rsp_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input bit expect_rsp, output int acc);
        int          n;
        logic        err;
        logic [33:0] e;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        acc       = cyc;
        cmd_valid = 1'b0;
        if (expect_rsp) begin
            err = (a[1:0] != 2'b00) || (a < 32'h400) || (a >= 32'h410);
            if (!err && wr) model_regs[a[3:2]] = d;
            e = {wr, err, 32'h0};
            if (!err && !wr) e[31:0] = model_regs[a[3:2]];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
        checks++; if (wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0)   begin errors++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
        checks++; if (rsp_wr !== 1'b0)    begin errors++; $display("FAIL reset_rsp_wr: got %b, required 0", rsp_wr); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (rsp_rdata !== '0)   begin errors++; $display("FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
        checks++; if (addr !== '0)        begin errors++; $display("FAIL reset_addr: got %h, required 0", addr); end
        checks++; if (wdata !== '0)       begin errors++; $display("FAIL reset_wdata: got %h, required 0", wdata); end
        checks++; if (txn_count !== '0)   begin errors++; $display("FAIL reset_txn_count: got %0d, required 0", txn_count); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
        reset = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    endtask

    task automatic test_write();
        int acc, p;
        rsp_ready = 1'b1;
        p = pulse_cnt;
        drive_cmd(1'b1, 32'h404, 32'hDEADBEEF, 1'b1, acc);
        checks++; if (valid !== 1'b1)        begin errors++; $display("FAIL wr_issue_valid: got %b, required 1", valid); end
        checks++; if (wr_en !== 1'b1)        begin errors++; $display("FAIL wr_issue_wr_en: got %b, required 1", wr_en); end
        checks++; if (addr !== 32'h404)      begin errors++; $display("FAIL wr_issue_addr: got %h, required 404", addr); end
        checks++; if (wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_issue_wdata: got %h, required deadbeef", wdata); end
        checks++; if (cmd_ready !== 1'b0)    begin errors++; $display("FAIL wr_issue_cmd_ready: got %b, required 0", cmd_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1)    begin errors++; $display("FAIL wr_rsp_latency: rsp_valid=%b, required 1", rsp_valid); end
        checks++; if (valid !== 1'b0)        begin errors++; $display("FAIL wr_valid_drop: got %b, required 0", valid); end
        checks++; if (rsp_err !== 1'b0)      begin errors++; $display("FAIL wr_rsp_err: got %b, required 0", rsp_err); end
        tick();
        checks++; if (pulse_cnt - p != 1)    begin errors++; $display("FAIL wr_pulse_count: got %0d, required 1", pulse_cnt - p); end
        checks++; if (txn_count !== 8'd1)    begin errors++; $display("FAIL wr_txn_count: got %0d, required 1", txn_count); end
        checks++; if (cmd_ready !== 1'b1)    begin errors++; $display("FAIL wr_cmd_ready_back: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        int acc;
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h40C, 32'h12345678, 1'b1, acc);
        wait_idle();
        drive_cmd(1'b0, 32'h404, 32'h0, 1'b1, acc);
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL rd_issue_valid: got %b, required 1", valid); end
        checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL rd_issue_wr_en: got %b, required 0", wr_en); end
        checks++; if (addr !== 32'h404) begin errors++; $display("FAIL rd_issue_addr: got %h, required 404", addr); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_capt_rsp_valid: got %b, required 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_latency: rsp_valid=%b, required 1", rsp_valid); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h, required deadbeef", rsp_rdata); end
        wait_idle();
    endtask

    task automatic test_errors();
        logic [31:0] bad_addr [3];
        logic        bad_wr   [3];
        int          acc, p;
        bad_addr[0] = 32'h410; bad_wr[0] = 1'b0;
        bad_addr[1] = 32'h402; bad_wr[1] = 1'b0;
        bad_addr[2] = 32'h3FC; bad_wr[2] = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p = pulse_cnt;
            drive_cmd(bad_wr[i], bad_addr[i], 32'hA5A5A5A5, 1'b1, acc);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err_latency[%0d]: rsp_valid=%b, required 1", i, rsp_valid); end
            checks++; if (rsp_err !== 1'b1)   begin errors++; $display("FAIL err_flag[%0d]: got %b, required 1", i, rsp_err); end
            checks++; if (rsp_rdata !== '0)   begin errors++; $display("FAIL err_rdata[%0d]: got %h, required 0", i, rsp_rdata); end
            checks++; if (rsp_wr !== bad_wr[i]) begin errors++; $display("FAIL err_rsp_wr[%0d]: got %b, required %b", i, rsp_wr, bad_wr[i]); end
            tick();
            checks++; if (pulse_cnt != p)     begin errors++; $display("FAIL err_no_bus[%0d]: %0d pulses, required 0", i, pulse_cnt - p); end
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL err_cmd_ready[%0d]: got %b, required 1", i, cmd_ready); end
        end
    endtask

    task automatic test_backpressure();
        int acc, p;
        rsp_ready = 1'b0;
        drive_cmd(1'b0, 32'h40C, 32'h0, 1'b1, acc);
        tick();
        tick();
        p = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid[%0d]: got %b, required 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL bp_rdata[%0d]: got %h, required 12345678", i, rsp_rdata); end
            checks++; if ({rsp_wr, rsp_err} !== 2'b00) begin errors++; $display("FAIL bp_fields[%0d]: wr/err=%b, required 00", i, {rsp_wr, rsp_err}); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d]: got %b, required 0", i, cmd_ready); end
            checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL bp_valid[%0d]: got %b, required 0", i, valid); end
            // A competing command must not be taken while the response waits.
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h400; cmd_wdata = 32'h0BAD0BAD;
            tick();
        end
        cmd_valid = 1'b0;
        checks++; if (pulse_cnt != p) begin errors++; $display("FAIL bp_no_bus: %0d pulses, required 0", pulse_cnt - p); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL bp_release_state: got %0d, required 0", dbg_state); end
        checks++; if (txn_count !== CNT_W'(rsp_seen)) begin errors++; $display("FAIL bp_txn_count: got %0d, required %0d", txn_count, CNT_W'(rsp_seen)); end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit saw_rsp;
        rsp_ready = 1'b1;
        drive_cmd(1'b1, 32'h408, 32'hCAFEF00D, 1'b0, acc);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rm_issue_valid: got %b, required 1", valid); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rm_valid_async: got %b, required 0", valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rm_busy: got %b, required 0", busy); end
        checks++; if (txn_count !== '0)   begin errors++; $display("FAIL rm_txn_count: got %0d, required 0", txn_count); end
        rsp_seen = 0;
        repeat (2) tick();
        reset = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
            tick();
        end
        checks++; if (saw_rsp)            begin errors++; $display("FAIL rm_no_response: got rsp_valid=1, required 0"); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rm_state: got %0d, required 0", dbg_state); end
        drive_cmd(1'b0, 32'h408, 32'h0, 1'b1, acc);
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_readback_valid: got %b, required 1", rsp_valid); end
        checks++; if (rsp_rdata !== '0)   begin errors++; $display("FAIL rm_readback_rdata: got %h, required 0", rsp_rdata); end
        wait_idle();
        checks++; if (txn_count !== 8'd1) begin errors++; $display("FAIL rm_count_after: got %0d, required 1", txn_count); end
    endtask

    task automatic test_back_to_back();
        int          acc, prev_acc, kind, prev_kind, gap;
        logic        wr;
        logic [31:0] a;
        rsp_ready = 1'b1;
        prev_acc  = 0;
        prev_kind = 0;
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2) begin
                wr = 1'b0;
                a  = ($urandom_range(0, 1) == 0) ? 32'h401 + 4 * $urandom_range(0, 3)
                                                  : 32'h410 + 4 * $urandom_range(0, 8);
            end else begin
                wr = (kind == 0);
                a  = 32'h400 + 4 * $urandom_range(0, 3);
            end
            drive_cmd(wr, a, $urandom, 1'b1, acc);
            if (i > 0) begin
                gap = (prev_kind == 0) ? 3 : (prev_kind == 1) ? 4 : 2;
                checks++;
                if (acc - prev_acc != gap) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", i, acc - prev_acc, gap);
                end
            end
            prev_acc  = acc;
            prev_kind = kind;
        end
        wait_idle();
        checks++; if (txn_count !== CNT_W'(rsp_seen)) begin errors++; $display("FAIL b2b_txn_count: got %0d, required %0d", txn_count, CNT_W'(rsp_seen)); end
    endtask

    task automatic test_wrap();
        int acc, guard;
        rsp_ready = 1'b1;
        guard = 0;
        while ((rsp_seen % 256) != 255 && guard < 600) begin
            drive_cmd(1'b1, 32'h400, $urandom, 1'b1, acc);
            wait_idle();
            guard++;
        end
        checks++; if (txn_count !== 8'hFF) begin errors++; $display("FAIL wrap_preload: got %0d, required 255", txn_count); end
        drive_cmd(1'b1, 32'h400, 32'h5A5A0001, 1'b1, acc);
        wait_idle();
        checks++; if (txn_count !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0d, required 0", txn_count); end
        drive_cmd(1'b0, 32'h400, 32'h0, 1'b1, acc);
        wait_idle();
        checks++; if (txn_count !== 8'h01) begin errors++; $display("FAIL wrap_after: got %0d, required 1", txn_count); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < 4; i++) begin
            model_regs[i] = '0;
            slave_regs[i] = '0;
        end
        test_reset();
        test_write();
        test_write_read();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
